// File: rtl/cv32e41p_hwloop_ctrl.sv
// Hardware-loop controller: detects loop-end retirement and requests a counter decrement
// and a held loop-back jump to fetch, squashing ID while the jump is outstanding.
module cv32e41p_hwloop_ctrl #(
  parameter int unsigned N_REGS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc_id_i,
  input  logic              instr_valid_i,
  input  logic              id_valid_i,
  input  logic [31:0]       hwlp_start_addr_i [N_REGS],
  input  logic [31:0]       hwlp_end_addr_i   [N_REGS],
  input  logic [31:0]       hwlp_counter_i    [N_REGS],
  input  logic              flush_i,
  input  logic              jump_ack_i,
  output logic [N_REGS-1:0] hwlp_dec_cnt_o,
  output logic              hwlp_jump_o,
  output logic [31:0]       hwlp_targ_addr_o,
  output logic              hwlp_squash_o
);

  typedef enum logic [0:0] {StIdle, StJumpPend} state_e;

  state_e            state_q, state_d;
  logic [31:0]       targ_q, targ_d;
  logic [N_REGS-1:0] hit;
  logic [N_REGS-1:0] sel_oh;
  logic              any_hit;
  logic [31:0]       sel_start;
  logic [31:0]       sel_cnt;
  logic              fire;

  always_comb begin
    for (int unsigned k = 0; k < N_REGS; k++) begin
      hit[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 32'd0);
    end
  end

  // Lowest index wins, so a shared end address only ever services the innermost loop.
  always_comb begin
    sel_oh    = '0;
    sel_start = '0;
    sel_cnt   = '0;
    any_hit   = 1'b0;
    for (int unsigned k = 0; k < N_REGS; k++) begin
      if (hit[k] && !any_hit) begin
        any_hit   = 1'b1;
        sel_oh[k] = 1'b1;
        sel_start = hwlp_start_addr_i[k];
        sel_cnt   = hwlp_counter_i[k];
      end
    end
  end

  assign fire = instr_valid_i && id_valid_i && !flush_i && (state_q == StIdle) && any_hit;

  always_comb begin
    state_d = state_q;
    targ_d  = targ_q;
    unique case (state_q)
      StIdle: begin
        // A count of 1 is the final iteration: decrement only, fall through.
        if (fire && (sel_cnt > 32'd1)) begin
          state_d = StJumpPend;
          targ_d  = sel_start;
        end
      end
      StJumpPend: begin
        if (jump_ack_i || flush_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      targ_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      targ_q  <= targ_d;
    end
  end

  assign hwlp_dec_cnt_o   = fire ? sel_oh : '0;
  assign hwlp_jump_o      = (state_q == StJumpPend);
  assign hwlp_squash_o    = (state_q == StJumpPend);
  assign hwlp_targ_addr_o = targ_q;

endmodule

// File: tb/tb_cv32e41p_hwloop_ctrl.sv
// Scoreboard bench for cv32e41p_hwloop_ctrl: the bench acts as the loop register file and
// predicts every cycle's outputs from the loop rules; a negedge monitor compares.
module tb_cv32e41p_hwloop_ctrl;
  localparam int unsigned NR = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   pc;
  logic          iv, idv, fl, ack;
  logic [31:0]   st_i [NR];
  logic [31:0]   en_i [NR];
  logic [31:0]   ct_i [NR];
  logic [NR-1:0] dec_o;
  logic          jump_o, squash_o;
  logic [31:0]   targ_o;

  always #5 clk = ~clk;

  cv32e41p_hwloop_ctrl #(.N_REGS(NR)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pc_id_i          (pc),
    .instr_valid_i    (iv),
    .id_valid_i       (idv),
    .hwlp_start_addr_i(st_i),
    .hwlp_end_addr_i  (en_i),
    .hwlp_counter_i   (ct_i),
    .flush_i          (fl),
    .jump_ack_i       (ack),
    .hwlp_dec_cnt_o   (dec_o),
    .hwlp_jump_o      (jump_o),
    .hwlp_targ_addr_o (targ_o),
    .hwlp_squash_o    (squash_o)
  );

  // Reference model: register-file contents plus "a jump is owed to fetch" and its target.
  logic [31:0] st_m [NR];
  logic [31:0] en_m [NR];
  logic [31:0] ct_m [NR];
  logic        pend_m;
  logic [31:0] targ_m;

  typedef struct packed {
    logic [NR-1:0] dec;
    logic          jump;
    logic          squash;
    logic [31:0]   targ;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input logic [31:0] p, input logic v, input logic d, input logic f,
                      input logic a);
    exp_t          e;
    logic [NR-1:0] dec;
    int            sel;
    @(posedge clk);
    #1;
    pc = p; iv = v; idv = d; fl = f; ack = a;
    for (int k = 0; k < NR; k++) begin
      st_i[k] = st_m[k];
      en_i[k] = en_m[k];
      ct_i[k] = ct_m[k];
    end
    sel = -1;
    for (int k = NR - 1; k >= 0; k--) begin
      if (p == en_m[k] && ct_m[k] != 32'd0) sel = k;
    end
    dec = '0;
    if (v && d && !f && !pend_m && sel >= 0) dec = NR'(1) << sel;
    e.dec = dec; e.jump = pend_m; e.squash = pend_m; e.targ = targ_m;
    q.push_back(e);
    if (pend_m) begin
      if (a || f) pend_m = 1'b0;
    end else if (dec != '0) begin
      if (ct_m[sel] >= 32'd2) begin
        pend_m = 1'b1;
        targ_m = st_m[sel];
      end
      ct_m[sel] = ct_m[sel] - 32'd1;
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (dec_o !== '0 || jump_o !== 1'b0 || squash_o !== 1'b0 || targ_o !== 32'd0) begin
      errors++;
      $display("FAIL %s: got dec=%b jump=%b squash=%b targ=%h, want all zero", name, dec_o,
               jump_o, squash_o, targ_o);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    q.delete();
    pend_m = 1'b0;
    targ_m = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({dec_o, jump_o, squash_o, targ_o} !== e) begin
        errors++;
        $display("FAIL scoreboard t=%0t: got dec=%b jump=%b squash=%b targ=%h, want dec=%b jump=%b squash=%b targ=%h",
                 $time, dec_o, jump_o, squash_o, targ_o, e.dec, e.jump, e.squash, e.targ);
      end
    end
  end

  initial begin
    pc = '0; iv = 0; idv = 0; fl = 0; ack = 0;
    st_m[0] = 32'h100; en_m[0] = 32'h10C; ct_m[0] = 32'd3;
    st_m[1] = 32'h200; en_m[1] = 32'h140; ct_m[1] = 32'd0;
    pend_m = 1'b0; targ_m = 32'd0;
    for (int k = 0; k < NR; k++) begin
      st_i[k] = st_m[k]; en_i[k] = en_m[k]; ct_i[k] = ct_m[k];
    end
    #1 check_zero("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single loop: three retirements, two jumps, last one falls through.
    step(32'h10C, 1, 1, 0, 0); step(32'h110, 0, 0, 0, 1);
    step(32'h100, 1, 1, 0, 0); step(32'h10C, 1, 1, 0, 0); step(32'h110, 0, 0, 0, 1);
    step(32'h10C, 1, 1, 0, 0); step(32'h110, 1, 1, 0, 0);
    // Nested priority.
    st_m[0] = 32'h104; en_m[0] = 32'h120; ct_m[0] = 32'd2;
    st_m[1] = 32'h100; en_m[1] = 32'h140; ct_m[1] = 32'd5;
    step(32'h120, 1, 1, 0, 0); step(32'h0, 0, 0, 0, 1);
    step(32'h140, 1, 1, 0, 0); step(32'h0, 0, 0, 0, 1); step(32'h0, 0, 0, 0, 0);
    // Stalled ack with the end instruction sitting in ID.
    st_m[0] = 32'h100; en_m[0] = 32'h10C; ct_m[0] = 32'd3;
    step(32'h10C, 1, 1, 0, 0);
    repeat (4) step(32'h10C, 1, 1, 0, 0);
    step(32'h10C, 1, 1, 0, 1); step(32'h0, 0, 0, 0, 0);
    // Stalled in ID: no decrement until retirement.
    step(32'h10C, 1, 0, 0, 0); step(32'h10C, 1, 0, 0, 0); step(32'h10C, 1, 1, 0, 0);
    step(32'h0, 0, 0, 0, 1);
    // Flush with the would-be fire, flush during pending, flush together with ack.
    ct_m[0] = 32'd4;
    step(32'h10C, 1, 1, 1, 0);
    step(32'h10C, 1, 1, 0, 0); step(32'h0, 0, 0, 1, 0); step(32'h0, 0, 0, 0, 1);
    step(32'h10C, 1, 1, 0, 0); step(32'h0, 0, 0, 1, 1); step(32'h0, 0, 0, 0, 0);
    // Large counter and reset while pending.
    ct_m[0] = 32'hFFFF_FFFF;
    step(32'h10C, 1, 1, 0, 0); step(32'h0, 0, 0, 0, 0);
    do_reset();
    step(32'h0, 0, 0, 0, 0); step(32'h0, 0, 0, 0, 1);

    // Randomized traffic with occasional register-file reprogramming.
    for (int n = 0; n < 3000; n++) begin
      int unsigned r;
      logic [31:0] p;
      for (int k = 0; k < NR; k++) begin
        if ($urandom_range(0, 31) == 0) begin
          st_m[k] = $urandom & 32'hFFFF_FFFC;
          en_m[k] = ($urandom_range(0, 3) == 0) ? en_m[1 - k] : (32'h100 + 4 * $urandom_range(0, 15));
          case ($urandom_range(0, 5))
            0: ct_m[k] = 32'd0;
            1: ct_m[k] = 32'd1;
            2: ct_m[k] = 32'd2;
            3: ct_m[k] = 32'hFFFF_FFFF;
            default: ct_m[k] = $urandom_range(3, 9);
          endcase
        end
      end
      r = $urandom_range(0, 9);
      p = (r < 4) ? en_m[0] : (r < 7) ? en_m[1] : ($urandom & 32'hFFFF_FFFC);
      step(p, $urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cv32e41p_hwloop_ctrl.md
# cv32e41p_hwloop_ctrl

Hardware-loop controller sitting directly downstream of the hardware-loop register file. It consumes the per-loop start, end and counter values and watches the ID-stage PC. It issues a one-hot counter-decrement request back to the register file when a loop-end instruction retires, and a registered, held jump request to the fetch stage when another iteration is required. While a jump is outstanding it tells ID to squash fall-through instructions.

## Interface
Parameters:
- N_REGS, 2, number of hardware loops; index 0 is innermost and has the highest priority.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- pc_id_i  in  32  PC of the instruction currently in ID.
- instr_valid_i  in  1  ID holds a real, non-squashed instruction.
- id_valid_i  in  1  the ID instruction retires to EX this cycle; same signal that drives the register file's valid_i.
- hwlp_start_addr_i  in  N_REGS×32  loop start addresses.
- hwlp_end_addr_i  in  N_REGS×32  loop end addresses, i.e. the address of the last loop-body instruction.
- hwlp_counter_i  in  N_REGS×32  remaining iterations, unsigned.
- flush_i  in  1  branch, exception or debug redirect; kills any pending loop jump.
- jump_ack_i  in  1  fetch accepts the jump request this cycle.
- hwlp_dec_cnt_o  out  N_REGS  one-hot decrement request to the register file.
- hwlp_jump_o  out  1  loop-back jump request to fetch.
- hwlp_targ_addr_o  out  32  jump target, stable while hwlp_jump_o=1.
- hwlp_squash_o  out  1  ID must treat its current instruction as invalid.

## Operation
- hit[k] = (pc_id_i == hwlp_end_addr_i[k]) && (hwlp_counter_i[k] != 0), evaluated per loop.
- sel = the lowest k with hit[k]=1. Only sel is serviced.
- Sharing an end address across loops is illegal software. If it happens, only the lowest index is serviced; no error is flagged.
- fire = instr_valid_i && id_valid_i && !flush_i && (state==IDLE) && any hit.
- hwlp_dec_cnt_o[sel] = fire. This is combinational, and at most one bit is ever set.
- FSM has two states, IDLE and JUMP_PEND.
  - IDLE → JUMP_PEND when fire && hwlp_counter_i[sel] >= 2. The block captures targ_q = hwlp_start_addr_i[sel] at that edge.
  - If fire && hwlp_counter_i[sel] == 1, this is the last iteration. The counter goes to 0, the FSM stays in IDLE, and execution falls through.
  - JUMP_PEND → IDLE on jump_ack_i || flush_i.
- hwlp_jump_o = (state==JUMP_PEND). hwlp_targ_addr_o = targ_q, held constant until the FSM leaves JUMP_PEND.
- hwlp_squash_o = (state==JUMP_PEND). While squashing:
  - no hit is serviced;
  - hwlp_dec_cnt_o = 0.
- Counter comparisons are 32-bit unsigned; a counter value of 0xFFFFFFFF counts as >= 2. The block performs no arithmetic on the counters; the register file does the decrement.
- A register-file write arriving during JUMP_PEND does not alter targ_q. Its effect is visible on the next hit.

## Timing
- Reset values: state=IDLE, targ_q=0. Outputs hwlp_jump_o=0, hwlp_targ_addr_o=0, hwlp_squash_o=0, hwlp_dec_cnt_o=0. Reset is honoured in any state, including mid-JUMP_PEND.
- Cycle N: a loop-end instruction retires; hwlp_dec_cnt_o pulses in cycle N. The register file shows counter-1 in cycle N+1.
- Cycle N+1: hwlp_jump_o=1 and hwlp_squash_o=1.
- Jump is held until the first rising edge with jump_ack_i=1; it is deasserted in the following cycle. If ack arrives in N+1, the jump is low from N+2.
- A hit stalled in ID (instr_valid_i=1, id_valid_i=0) produces no decrement and no jump until the cycle the instruction retires.
- flush_i behaviour:
  - same cycle as a would-be fire: no decrement, no jump;
  - during JUMP_PEND: the request is dropped next cycle, and ack is ignored;
  - together with jump_ack_i: the FSM returns to IDLE.
- Back-to-back iterations: after the jump is acked, the next retirement of the end instruction may fire in any cycle once the FSM is in IDLE. Minimum loop-body throughput is bounded by fetch, not by this block.

## Test plan
- Single-loop iterations:
  - Stimulus: start=0x100, end=0x10C, counter=3; end instruction retires three times, with ack one cycle after each jump.
  - Required response: dec pulses 3×; jump to 0x100 twice; third retirement decrements with no jump; counter ends at 0.
- Last iteration:
  - Stimulus: counter=1 at the end retirement.
  - Required response: dec_cnt_o=01, hwlp_jump_o stays 0, squash stays 0.
- Nested priority:
  - Stimulus: loop0 end=0x120, counter=2; loop1 end=0x140, counter=5. PC 0x120 retires, then PC 0x140 retires.
  - Required response: dec=01 with jump to start[0], then dec=10 with jump to start[1]. dec_cnt_o is never 11.
- Stalled ack:
  - Stimulus: hold jump_ack_i=0 for 4 cycles after the jump; present pc_id_i=0x10C with instr_valid_i=id_valid_i=1 during that time.
  - Required response: jump and target stay stable; squash=1; no extra dec pulse. Jump clears one cycle after ack.
- Flush:
  - Stimulus A: flush_i in the same cycle as the end retirement. Required response: no dec, no jump.
  - Stimulus B: flush_i during JUMP_PEND. Required response: jump drops next cycle, counter already decremented once.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 while in JUMP_PEND.
  - Required response: jump, squash and target are 0 immediately (asynchronously), and stay 0 after rst_n releases.
